// File: rtl/add128_slice_seq.sv
// add128_slice_seq: slice-serial sequencer in front of an external 7-bit slice adder.
// It takes a WIDTH-bit operand pair, sends it to the slice adder one SLICE-bit slice per
// clock (LSB slice first), ripples the carry between slices, and returns the packed sum.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake; in_a, in_b are the operands
//   slice_a/slice_b         slice operands sent to the slice adder; slice_en marks a live slice
//   slice_f                 slice adder result (SLICE+1 bits, combinational, same cycle)
//   out_valid/out_ready     result handshake; out_sum is the sum mod 2^WIDTH, out_cout is bit WIDTH
module add128_slice_seq #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned SLICE = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [SLICE-1:0] slice_a,
   output logic [SLICE-1:0] slice_b,
   input  logic [SLICE:0]   slice_f,
   output logic             slice_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int unsigned NUM_SLICES = (WIDTH + SLICE - 1) / SLICE;
   localparam int unsigned PAD_W      = NUM_SLICES * SLICE;
   localparam int unsigned SF_W       = SLICE + 1;
   localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [PAD_W-1:0]   a_pad_q, a_pad_d;
   logic [PAD_W-1:0]   b_pad_q, b_pad_d;
   logic [PAD_W-1:0]   sum_pad_q, sum_pad_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               slice_en_q, slice_en_d;
   logic [SLICE-1:0]   slice_a_q, slice_a_d;
   logic [SLICE-1:0]   slice_b_q, slice_b_d;
   logic [SLICE:0]     r;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_pad_q     <= '0;
         b_pad_q     <= '0;
         sum_pad_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         slice_en_q  <= 1'b0;
         slice_a_q   <= '0;
         slice_b_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_pad_q     <= a_pad_d;
         b_pad_q     <= b_pad_d;
         sum_pad_q   <= sum_pad_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         slice_en_q  <= slice_en_d;
         slice_a_q   <= slice_a_d;
         slice_b_q   <= slice_b_d;
      end
   end

   // Next-state, slice accumulation and registered-output decode
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_pad_d   = a_pad_q;
      b_pad_d   = b_pad_q;
      sum_pad_d = sum_pad_q;
      r         = '0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_pad_d = PAD_W'(in_a);
               b_pad_d = PAD_W'(in_b);
               idx_d   = '0;
               carry_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            // 127 + 127 + 1 = 255 fits in SLICE+1 bits, so no overflow here
            r = slice_f + SF_W'(carry_q);
            sum_pad_d[idx_q*SLICE +: SLICE] = r[SLICE-1:0];
            carry_d = r[SLICE];
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with it
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      slice_en_d  = (state_d == RUN);
      slice_a_d   = slice_en_d ? a_pad_d[idx_d*SLICE +: SLICE] : '0;
      slice_b_d   = slice_en_d ? b_pad_d[idx_d*SLICE +: SLICE] : '0;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign slice_en  = slice_en_q;
   assign slice_a   = slice_a_q;
   assign slice_b   = slice_b_q;
   assign out_sum   = sum_pad_q[WIDTH-1:0];
   // Operand padding is zero, so only bit WIDTH of the padded top can be set: the OR is the carry-out
   assign out_cout  = |sum_pad_q[PAD_W-1:WIDTH];

endmodule

// File: tb/tb_add128_slice_seq.sv
// tb_add128_slice_seq: table-driven and random checks of add128_slice_seq with a behavioural
// 7-bit slice adder and a scoreboard queue of expected {cout, sum} values.
module tb_add128_slice_seq;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_a;
   logic [127:0] in_b;
   logic [6:0]   slice_a;
   logic [6:0]   slice_b;
   logic [7:0]   slice_f;
   logic         slice_en;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_sum;
   logic         out_cout;

   int errors = 0;
   int checks = 0;
   logic [128:0] sb[$];

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] sum;
      logic         cout;
      int           stall;
      bit           poke;
   } vec_t;

   vec_t vecs[8];

   add128_slice_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .slice_a   (slice_a),
      .slice_b   (slice_b),
      .slice_f   (slice_f),
      .slice_en  (slice_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   // External slice adder; drives junk when no slice is live so a leak would show up
   assign slice_f = slice_en ? ({1'b0, slice_a} + {1'b0, slice_b}) : 8'hA5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full operation: accept, run, optional stall in DONE, scoreboard compare at handshake
   task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic [128:0] exp,
                        input int stall, input bit poke);
      int n;
      int en_cnt;
      bit busy_ok;
      bit stable_ok;
      logic [128:0] held;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check("idle_in_ready", 160'(in_ready), 160'(1));
      in_a = a; in_b = b; in_valid = 1'b1;
      sb.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = rand128(); in_b = rand128();
      n = 1; en_cnt = 0; busy_ok = 1'b1;
      while (!out_valid && n < 40) begin
         if (slice_en) en_cnt++;
         if (in_ready) busy_ok = 1'b0;
         if (poke && n == 5) begin
            in_valid = 1'b1; in_a = rand128(); in_b = rand128();
         end
         @(posedge clk); #1; n++;
      end
      check("latency_edges", 160'(n), 160'(20));
      check("slice_en_cycles", 160'(en_cnt), 160'(19));
      if (!out_valid) begin
         in_valid = 1'b0;
         void'(sb.pop_front());
         return;
      end
      held = {out_cout, out_sum};
      stable_ok = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         if (!out_valid || {out_cout, out_sum} !== held) stable_ok = 1'b0;
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
      if (stall > 0) check("hold_stable", 160'(stable_ok), 160'(1));
      if (poke) check("busy_in_ready_low", 160'(busy_ok), 160'(1));
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 160'(1), 160'(0));
      end else begin
         check("sum_cout", 160'({out_cout, out_sum}), 160'(sb.pop_front()));
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_handshake", 160'({out_valid, in_ready}), 160'(2'b01));
   endtask

   initial begin
      int n;
      bit pulse;
      logic [127:0] ones;
      logic [127:0] ra;
      logic [127:0] rb;

      ones = '1;
      vecs[0] = '{a: 128'h0,            b: 128'h0,            sum: 128'h0,        cout: 1'b0, stall: 0, poke: 1'b0};
      vecs[1] = '{a: 128'h7F,           b: 128'h1,            sum: 128'h80,       cout: 1'b0, stall: 1, poke: 1'b0};
      vecs[2] = '{a: ones,              b: 128'h1,            sum: 128'h0,        cout: 1'b1, stall: 0, poke: 1'b0};
      vecs[3] = '{a: ones,              b: ones,              sum: ones - 128'd1, cout: 1'b1, stall: 2, poke: 1'b0};
      vecs[4] = '{a: 128'h3FFF,         b: 128'h1,            sum: 128'h4000,     cout: 1'b0, stall: 0, poke: 1'b0};
      vecs[5] = '{a: {128{1'b0}} | (128'h1 << 127), b: 128'h1 << 127, sum: 128'h0, cout: 1'b1, stall: 8, poke: 1'b1};
      vecs[6] = '{a: 128'h1 << 126,     b: 128'h1 << 126,     sum: 128'h1 << 127, cout: 1'b0, stall: 0, poke: 1'b0};
      vecs[7] = '{a: {32{4'h5}},        b: {32{4'hA}},        sum: ones,          cout: 1'b0, stall: 3, poke: 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", 160'({in_ready, out_valid, slice_en, slice_a, slice_b}), 160'({3'b100, 14'h0}));
      check("reset_sum", 160'({out_cout, out_sum}), 160'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, {vecs[i].cout, vecs[i].sum}, vecs[i].stall, vecs[i].poke);
      end

      // Abort by reset at idx 9 of RUN
      in_a = ones; in_b = 128'h1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("mid_run_slice", 160'({slice_en, slice_a, slice_b}), 160'({1'b1, 7'h7F, 7'h00}));
      rst_n = 1'b0;
      #1;
      check("abort_ctrl", 160'({in_ready, out_valid, slice_en, slice_a, slice_b}), 160'({3'b100, 14'h0}));
      check("abort_sum", 160'({out_cout, out_sum}), 160'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulse = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) pulse = 1'b1;
      end
      check("no_pulse_after_abort", 160'(pulse), 160'(0));
      do_op(128'd5, 128'd7, 129'd12, 0, 1'b0);

      // Random operands against a 129-bit reference sum
      for (int i = 0; i < 1000; i++) begin
         ra = rand128();
         rb = rand128();
         if ($urandom_range(0, 15) == 0) ra = ones;
         if ($urandom_range(0, 15) == 0) rb = ~ra;
         do_op(ra, rb, {1'b0, ra} + {1'b0, rb}, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
